// File: rtl/trace_pkg.sv
// trace_pkg: command codes, channel op encodings, barrier FSM states and decode helpers
package trace_pkg;
  typedef enum logic [3:0] {
    CMD_DR    = 4'd0,
    CMD_DW    = 4'd1,
    CMD_IR    = 4'd2,
    CMD_SNP_I = 4'd3,
    CMD_SNP_R = 4'd4,
    CMD_SNP_W = 4'd5,
    CMD_SNP_M = 4'd6,
    CMD_CLEAR = 4'd8,
    CMD_PRINT = 4'd9
  } cmd_e;
  typedef enum logic [1:0] {L1_DR, L1_DW, L1_IR} l1_op_e;
  typedef enum logic [1:0] {SNP_I, SNP_R, SNP_W, SNP_M} snp_op_e;
  typedef enum logic {IDLE, PULSE} state_e;
  function automatic logic is_l1(input logic [3:0] c);
    return c <= CMD_IR;
  endfunction
  function automatic logic is_snoop(input logic [3:0] c);
    return c >= CMD_SNP_I && c <= CMD_SNP_M;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with a registered output stage; occupancy includes the output register
module trace_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic load;
  assign load = (cnt != '0) && (!valid || pop);
  assign empty = cnt == '0;
  assign full = (cnt + {{AW{1'b0}}, valid}) == (AW+1)'(DEPTH);
  // storage array, written on push only
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers, occupancy and output register refill
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= load ? rp + AW'(1) : rp;
      dout <= load ? mem[rp] : dout;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(load);
      valid <= load ? 1'b1 : pop ? 1'b0 : valid;
    end
endmodule

// File: rtl/trace_dispatcher.sv
// trace_dispatcher: routes trace records to L1/snoop FIFOs and barrier pulses; TRACE_DISPATCH_STATS_EN enables counters
module trace_dispatcher
  import trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CMD_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              l1_valid,
  input  logic              l1_ready,
  output logic [1:0]        l1_op,
  output logic [ADDR_W-1:0] l1_addr,
  output logic              snp_valid,
  input  logic              snp_ready,
  output logic [1:0]        snp_op,
  output logic [ADDR_W-1:0] snp_addr,
  output logic              clear_pulse,
  output logic              print_pulse,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  stat_l1,
  output logic [CNT_W-1:0]  stat_snp,
  output logic [CNT_W-1:0]  stat_err
);
  logic [3:0] lo, snp_idx;
  logic hi0, l1_cmd, snp_cmd, bar_cmd, acc;
  logic l1_full, l1_empty, snp_full, snp_empty;
  logic [ADDR_W+1:0] l1_q, snp_q;
  state_e state;
  assign lo = in_cmd[3:0];
  assign hi0 = (in_cmd >> 4) == '0;
  assign l1_cmd = hi0 && is_l1(lo);
  assign snp_cmd = hi0 && is_snoop(lo);
  assign bar_cmd = hi0 && (lo == CMD_CLEAR || lo == CMD_PRINT);
  assign snp_idx = lo - 4'd3;
  assign in_ready = state == PULSE ? 1'b0 :
                    l1_cmd  ? !l1_full :
                    snp_cmd ? !snp_full :
                    bar_cmd ? (l1_empty && snp_empty && !l1_valid && !snp_valid) : 1'b1;
  assign acc = in_valid && in_ready;
  assign {l1_op, l1_addr} = l1_q;
  assign {snp_op, snp_addr} = snp_q;
  trace_fifo #(.W(ADDR_W+2), .DEPTH(DEPTH)) u_l1 (
    .clk(clk), .rst(rst), .push(acc && l1_cmd), .din({lo[1:0], in_addr}),
    .pop(l1_valid && l1_ready), .dout(l1_q), .valid(l1_valid), .full(l1_full), .empty(l1_empty)
  );
  trace_fifo #(.W(ADDR_W+2), .DEPTH(DEPTH)) u_snp (
    .clk(clk), .rst(rst), .push(acc && snp_cmd), .din({snp_idx[1:0], in_addr}),
    .pop(snp_valid && snp_ready), .dout(snp_q), .valid(snp_valid), .full(snp_full), .empty(snp_empty)
  );
  // barrier FSM: one pulse cycle after an accepted clear/print, plus the undefined-code pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      clear_pulse <= 1'b0;
      print_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= (state == IDLE && acc && bar_cmd) ? PULSE : IDLE;
      clear_pulse <= acc && bar_cmd && lo == CMD_CLEAR;
      print_pulse <= acc && bar_cmd && lo == CMD_PRINT;
      err_pulse <= acc && !l1_cmd && !snp_cmd && !bar_cmd;
    end
`ifdef TRACE_DISPATCH_STATS_EN
  // saturating acceptance counters, zeroed by an accepted clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_l1 <= '0;
      stat_snp <= '0;
      stat_err <= '0;
    end else if (acc && bar_cmd && lo == CMD_CLEAR) begin
      stat_l1 <= '0;
      stat_snp <= '0;
      stat_err <= '0;
    end else begin
      stat_l1 <= (acc && l1_cmd && stat_l1 != '1) ? stat_l1 + CNT_W'(1) : stat_l1;
      stat_snp <= (acc && snp_cmd && stat_snp != '1) ? stat_snp + CNT_W'(1) : stat_snp;
      stat_err <= (acc && !l1_cmd && !snp_cmd && !bar_cmd && stat_err != '1) ? stat_err + CNT_W'(1) : stat_err;
    end
`else
  assign stat_l1 = '0;
  assign stat_snp = '0;
  assign stat_err = '0;
`endif
endmodule

// File: tb/tb_trace_dispatcher.sv
// tb_trace_dispatcher: directed and random stimulus checked against a queue-based reference model
module tb_trace_dispatcher;
  localparam int DEPTH = 4;
`ifdef TRACE_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_cmd = '0;
  logic [31:0] in_addr = '0;
  logic l1_valid, l1_ready = 1'b0, snp_valid, snp_ready = 1'b0;
  logic [1:0] l1_op, snp_op;
  logic [31:0] l1_addr, snp_addr, stat_l1, stat_snp, stat_err;
  logic clear_pulse, print_pulse, err_pulse;

  trace_dispatcher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .clear_pulse(clear_pulse), .print_pulse(print_pulse), .err_pulse(err_pulse),
    .stat_l1(stat_l1), .stat_snp(stat_snp), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [31:0] addr;
    int vis;
  } ent_t;
  ent_t ql[$], qs[$];
  int cyc = 0, checks = 0, failures = 0;
  bit m_clr, m_prn, m_err, last_acc;
  longint m_sl, m_ss, m_se;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input logic [3:0] c);
    if (m_clr || m_prn) return 1'b0;
    if (c <= 4'd2) return ql.size() < DEPTH;
    if (c <= 4'd6) return qs.size() < DEPTH;
    if (c == 4'd8 || c == 4'd9) return ql.size() == 0 && qs.size() == 0;
    return 1'b1;
  endfunction

  task automatic cycle(input bit v, input logic [3:0] c, input logic [31:0] a, input bit lr, input bit sr);
    bit lv, sv, er, acc;
    logic [3:0] sidx;
    in_valid = v; in_cmd = c; in_addr = a; l1_ready = lr; snp_ready = sr;
    #1;
    lv = ql.size() > 0 && ql[0].vis <= cyc;
    sv = qs.size() > 0 && qs[0].vis <= cyc;
    er = exp_ready(c);
    chk("in_ready", in_ready, er);
    chk("l1_valid", l1_valid, lv);
    chk("snp_valid", snp_valid, sv);
    if (lv) begin
      chk("l1_op", l1_op, ql[0].op);
      chk("l1_addr", l1_addr, ql[0].addr);
    end
    if (sv) begin
      chk("snp_op", snp_op, qs[0].op);
      chk("snp_addr", snp_addr, qs[0].addr);
    end
    chk("clear_pulse", clear_pulse, m_clr);
    chk("print_pulse", print_pulse, m_prn);
    chk("err_pulse", err_pulse, m_err);
    chk("stat_l1", stat_l1, STATS ? m_sl[31:0] : 32'd0);
    chk("stat_snp", stat_snp, STATS ? m_ss[31:0] : 32'd0);
    chk("stat_err", stat_err, STATS ? m_se[31:0] : 32'd0);
    acc = v && er;
    last_acc = acc;
    @(posedge clk);
    if (lv && lr) void'(ql.pop_front());
    if (sv && sr) void'(qs.pop_front());
    sidx = c - 4'd3;
    if (acc && c <= 4'd2) ql.push_back('{c[1:0], a, cyc + 2});
    if (acc && c >= 4'd3 && c <= 4'd6) qs.push_back('{sidx[1:0], a, cyc + 2});
    m_clr = acc && c == 4'd8;
    m_prn = acc && c == 4'd9;
    m_err = acc && (c == 4'd7 || c > 4'd9);
    if (m_clr) begin
      m_sl = 0; m_ss = 0; m_se = 0;
    end else begin
      if (acc && c <= 4'd2) m_sl++;
      if (acc && c >= 4'd3 && c <= 4'd6) m_ss++;
      if (m_err) m_se++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit lr, input bit sr);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, lr, sr);
  endtask

  task automatic hold_until_acc(input logic [3:0] c, input bit lr_late, input bit sr_late, input int wait_low);
    int k;
    k = 0;
    last_acc = 1'b0;
    while (!last_acc && k < 40) begin
      cycle(1'b1, c, 32'hB0 + k, k >= wait_low ? lr_late : 1'b0, k >= wait_low ? sr_late : 1'b0);
      k++;
    end
    chk("barrier_accept", last_acc, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_l1_valid", l1_valid, 1'b0);
    chk("rst_snp_valid", snp_valid, 1'b0);
    chk("rst_pulses", {clear_pulse, print_pulse, err_pulse}, 3'b000);
    chk("rst_stats", {stat_l1, stat_snp, stat_err}, 96'd0);
    rst = 1'b0;
    // L1 in-order delivery
    cycle(1'b1, 4'd0, 32'h1000, 1'b1, 1'b1);
    cycle(1'b1, 4'd1, 32'h2000, 1'b1, 1'b1);
    cycle(1'b1, 4'd2, 32'h3000, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("stat_l1_three", stat_l1, STATS ? 32'd3 : 32'd0);
    // L1 back-pressure: fifth record refused, snoop channel still flows
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i % 3), 32'h500 + i, 1'b0, 1'b1);
    chk("l1_full_refuses", in_ready, 1'b0);
    cycle(1'b1, 4'd4, 32'hABC, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    idle(6, 1'b1, 1'b1);
    // print barrier waits for snoop drain
    cycle(1'b1, 4'd6, 32'h40, 1'b1, 1'b0);
    hold_until_acc(4'd9, 1'b1, 1'b1, 4);
    idle(3, 1'b1, 1'b1);
    // undefined codes
    cycle(1'b1, 4'd7, 32'h7, 1'b1, 1'b1);
    cycle(1'b1, 4'd15, 32'hF, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);
    chk("stat_err_two", stat_err, STATS ? 32'd2 : 32'd0);
    // clear after L1 traffic
    cycle(1'b1, 4'd0, 32'h10, 1'b1, 1'b1);
    cycle(1'b1, 4'd1, 32'h20, 1'b1, 1'b1);
    cycle(1'b1, 4'd2, 32'h30, 1'b1, 1'b1);
    hold_until_acc(4'd8, 1'b1, 1'b1, 0);
    idle(2, 1'b1, 1'b1);
    chk("stats_cleared", {stat_l1, stat_snp, stat_err}, 96'd0);
    // reset with both channels holding entries
    cycle(1'b1, 4'd0, 32'hA1, 1'b0, 1'b0);
    cycle(1'b1, 4'd3, 32'hB1, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 32'hA2, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 32'hB2, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_l1_valid", l1_valid, 1'b0);
    chk("midrst_snp_valid", snp_valid, 1'b0);
    ql.delete(); qs.delete();
    m_clr = 0; m_prn = 0; m_err = 0; m_sl = 0; m_ss = 0; m_se = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5, 1'b1, 1'b1);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    idle(12, 1'b1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
